// File: rtl/tlc_pkg.sv
// tlc_pkg: shared types, default timing and width helpers for the
// multi-approach traffic light controller. Optional feature macro used by
// the controller: TLC_PREEMPT_EN.
package tlc_pkg;

   typedef enum logic [1:0] {
      ST_ALL_RED = 2'd0,
      ST_GREEN   = 2'd1,
      ST_YELLOW  = 2'd2
   } tlc_state_e;

   localparam int DEF_N_WAY     = 4;
   localparam int DEF_MIN_GREEN = 4;
   localparam int DEF_MAX_GREEN = 10;
   localparam int DEF_YELLOW_T  = 3;
   localparam int DEF_ALLRED_T  = 2;

   // Width of an approach index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a timer that must hold the largest of the three durations.
   function automatic int tmr_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/tlc_multiway_if.sv
// tlc_multiway_if: sensor inputs and lamp outputs of the controller.
// With TLC_PREEMPT_EN defined, the preemption request signals are added.
interface tlc_multiway_if
   import tlc_pkg::*;
#(
   parameter int N_WAY = DEF_N_WAY
) ();

   logic [N_WAY-1:0]        t;
   logic [N_WAY-1:0]        r;
   logic [N_WAY-1:0]        y;
   logic [N_WAY-1:0]        g;
   logic [idx_w(N_WAY)-1:0] cur;
`ifdef TLC_PREEMPT_EN
   logic                    pre_req;
   logic [idx_w(N_WAY)-1:0] pre_idx;
`endif

   // Sensor / stimulus side.
   modport master (
`ifdef TLC_PREEMPT_EN
      output pre_req, pre_idx,
`endif
      output t,
      input  r, y, g, cur
   );

   // Controller side.
   modport slave (
`ifdef TLC_PREEMPT_EN
      input  pre_req, pre_idx,
`endif
      input  t,
      output r, y, g, cur
   );

endinterface

// File: rtl/tlc_rr_pick.sv
// tlc_rr_pick: combinational round-robin search. Returns the first approach
// with latched demand after cur (wrapping modulo N_WAY); cur itself when none.
module tlc_rr_pick
   import tlc_pkg::*;
#(
   parameter int N_WAY = DEF_N_WAY
) (
   input  logic [N_WAY-1:0]        dem,
   input  logic [idx_w(N_WAY)-1:0] cur,
   output logic                    found,
   output logic [idx_w(N_WAY)-1:0] next_idx
);

   localparam int IW = idx_w(N_WAY);

   logic [IW-1:0] pos;
   int unsigned   sum;

   // Scan offsets 1..N_WAY-1 from cur and keep the nearest demanding approach.
   always_comb begin
      found    = 1'b0;
      next_idx = cur;
      pos      = '0;
      sum      = 0;
      for (int unsigned k = 1; k < N_WAY; k++) begin
         sum = k + {{(32-IW){1'b0}}, cur};
         pos = IW'(sum % N_WAY);
         if (!found && dem[pos]) begin
            found    = 1'b1;
            next_idx = pos;
         end
      end
   end

endmodule

// File: rtl/tlc_multiway.sv
// tlc_multiway: N-approach round-robin traffic light controller with
// min/max green, fixed yellow and all-red clearance. Lamp outputs are
// registered. Optional emergency preemption under TLC_PREEMPT_EN.
module tlc_multiway
   import tlc_pkg::*;
#(
   parameter int N_WAY     = DEF_N_WAY,
   parameter int MIN_GREEN = DEF_MIN_GREEN,
   parameter int MAX_GREEN = DEF_MAX_GREEN,
   parameter int YELLOW_T  = DEF_YELLOW_T,
   parameter int ALLRED_T  = DEF_ALLRED_T
) (
   input logic           clk,
   input logic           rst,
   tlc_multiway_if.slave bus
);

   localparam int IW = idx_w(N_WAY);
   localparam int TW = tmr_w(MAX_GREEN, YELLOW_T, ALLRED_T);

   localparam logic [TW-1:0] MIN_G   = TW'(MIN_GREEN);
   localparam logic [TW-1:0] MAX_G   = TW'(MAX_GREEN);
   localparam logic [TW-1:0] Y_LAST  = TW'(YELLOW_T - 1);
   localparam logic [TW-1:0] AR_LAST = TW'(ALLRED_T - 1);

   tlc_state_e       state, nxt_state;
   logic [TW-1:0]    cnt, nxt_cnt;
   logic [TW-1:0]    gcnt, nxt_gcnt;
   logic [N_WAY-1:0] dem, nxt_dem;
   logic [IW-1:0]    cur_q, nxt_cur;
   logic             first_q, nxt_first;
   logic [N_WAY-1:0] r_q, y_q, g_q;
   logic [N_WAY-1:0] nxt_r, nxt_y, nxt_g;
   logic             other_dem, go_yel;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;

   tlc_rr_pick #(.N_WAY(N_WAY)) u_pick (
      .dem      (dem),
      .cur      (cur_q),
      .found    (pick_found),
      .next_idx (pick_idx)
   );

   assign other_dem = |(dem & ~(N_WAY'(1) << cur_q));

   // Next-state, timers, demand latch and lamp decode of the next state.
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_gcnt  = gcnt;
      nxt_dem   = dem | bus.t;
      nxt_cur   = cur_q;
      nxt_first = first_q;
      go_yel    = 1'b0;
      nxt_r     = '1;
      nxt_y     = '0;
      nxt_g     = '0;

      unique case (state)
         ST_ALL_RED: begin
            if (cnt == AR_LAST) begin
               nxt_state = ST_GREEN;
               nxt_cnt   = '0;
               nxt_gcnt  = TW'(1);
               nxt_first = 1'b0;
               if (first_q)         nxt_cur = '0;
               else if (pick_found) nxt_cur = pick_idx;
`ifdef TLC_PREEMPT_EN
               if (bus.pre_req)     nxt_cur = bus.pre_idx;
`endif
            end else begin
               nxt_cnt = cnt + TW'(1);
            end
         end
         ST_GREEN: begin
            nxt_dem[cur_q] = 1'b0;
            if (gcnt != MAX_G) nxt_gcnt = gcnt + TW'(1);
            go_yel = (gcnt >= MIN_G) && other_dem &&
                     (!bus.t[cur_q] || (gcnt >= MAX_G));
`ifdef TLC_PREEMPT_EN
            // Preemption overrides both the minimum green and the hold rules.
            if (bus.pre_req) go_yel = (bus.pre_idx != cur_q);
`endif
            if (go_yel) begin
               nxt_state = ST_YELLOW;
               nxt_cnt   = '0;
            end
         end
         ST_YELLOW: begin
            if (cnt == Y_LAST) begin
               nxt_state = ST_ALL_RED;
               nxt_cnt   = '0;
            end else begin
               nxt_cnt = cnt + TW'(1);
            end
         end
         default: begin
            nxt_state = ST_ALL_RED;
            nxt_cnt   = '0;
         end
      endcase

      if (nxt_state == ST_GREEN) begin
         nxt_g[nxt_cur] = 1'b1;
         nxt_r[nxt_cur] = 1'b0;
      end else if (nxt_state == ST_YELLOW) begin
         nxt_y[nxt_cur] = 1'b1;
         nxt_r[nxt_cur] = 1'b0;
      end
   end

   // State, timers, demand latch and registered lamp outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_ALL_RED;
         cnt     <= '0;
         gcnt    <= '0;
         dem     <= '0;
         cur_q   <= '0;
         first_q <= 1'b1;
         r_q     <= '1;
         y_q     <= '0;
         g_q     <= '0;
      end else begin
         state   <= nxt_state;
         cnt     <= nxt_cnt;
         gcnt    <= nxt_gcnt;
         dem     <= nxt_dem;
         cur_q   <= nxt_cur;
         first_q <= nxt_first;
         r_q     <= nxt_r;
         y_q     <= nxt_y;
         g_q     <= nxt_g;
      end
   end

   assign bus.r   = r_q;
   assign bus.y   = y_q;
   assign bus.g   = g_q;
   assign bus.cur = cur_q;

endmodule

// File: tb/tb_tlc_multiway.sv
// tb_tlc_multiway: scoreboard bench for tlc_multiway (default build; with
// TLC_PREEMPT_EN defined the preemption inputs are held inactive).
module tb_tlc_multiway;
   import tlc_pkg::*;

   localparam int N    = 4;
   localparam int MING = 4;
   localparam int MAXG = 10;
   localparam int YEL  = 3;
   localparam int AR   = 2;

   localparam int PH_RED = 0;
   localparam int PH_GRN = 1;
   localparam int PH_YEL = 2;

   typedef struct packed {
      logic [N-1:0] r;
      logic [N-1:0] y;
      logic [N-1:0] g;
      logic [1:0]   cur;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   tlc_multiway_if #(.N_WAY(N)) bus ();

   tlc_multiway #(
      .N_WAY     (N),
      .MIN_GREEN (MING),
      .MAX_GREEN (MAXG),
      .YELLOW_T  (YEL),
      .ALLRED_T  (AR)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   // Reference model: phase, 1-based cycle number within the phase,
   // cycles spent green, served approach and pending requests.
   int       m_phase = PH_RED;
   int       m_age   = 1;
   int       m_gage  = 0;
   int       m_cur   = 0;
   bit       m_first = 1'b1;
   bit [N-1:0] m_dem = '0;

   function automatic int next_served();
      for (int k = 1; k < N; k++) begin
         if (m_dem[(m_cur + k) % N]) return (m_cur + k) % N;
      end
      return m_cur;
   endfunction

   function automatic bit others_waiting();
      for (int j = 0; j < N; j++) begin
         if (j != m_cur && m_dem[j]) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_step(input bit rv, input bit [N-1:0] tv);
      bit [N-1:0] d_next;
      bit         leave;
      if (rv) begin
         m_phase = PH_RED; m_age = 1; m_gage = 0;
         m_cur = 0; m_dem = '0; m_first = 1'b1;
         return;
      end
      d_next = m_dem | tv;
      if (m_phase == PH_GRN) d_next[m_cur] = 1'b0;
      case (m_phase)
         PH_RED: begin
            if (m_age == AR) begin
               m_cur   = m_first ? 0 : next_served();
               m_first = 1'b0;
               m_phase = PH_GRN;
               m_gage  = 1;
            end else m_age++;
         end
         PH_GRN: begin
            leave = (m_gage >= MING) && others_waiting() &&
                    (!tv[m_cur] || m_gage >= MAXG);
            if (leave) begin
               m_phase = PH_YEL; m_age = 1;
            end else if (m_gage < MAXG) m_gage++;
         end
         default: begin
            if (m_age == YEL) begin
               m_phase = PH_RED; m_age = 1;
            end else m_age++;
         end
      endcase
      m_dem = d_next;
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.r = '1; e.y = '0; e.g = '0;
      e.cur = 2'(m_cur);
      if (m_phase != PH_RED) begin
         e.r[m_cur] = 1'b0;
         if (m_phase == PH_GRN) e.g[m_cur] = 1'b1;
         else                   e.y[m_cur] = 1'b1;
      end
      return e;
   endfunction

   // One cycle of stimulus: inputs change on the falling edge, expectation
   // for the state after the following rising edge goes to the scoreboard.
   task automatic step(input bit rv, input bit [N-1:0] tv);
      @(negedge clk);
      rst   = rv;
      bus.t = tv;
      model_step(rv, tv);
      sb.push_back(model_out());
   endtask

   // Monitor: the DUT presents new lamp outputs after every rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({bus.r, bus.y, bus.g} !== {e.r, e.y, e.g}) begin
               errors++;
               $display("FAIL lamps t=%0t: r/y/g got %b/%b/%b want %b/%b/%b",
                        $time, bus.r, bus.y, bus.g, e.r, e.y, e.g);
            end
            checks++;
            if (bus.cur !== e.cur) begin
               errors++;
               $display("FAIL cur t=%0t: got %0d want %0d", $time, bus.cur, e.cur);
            end
         end
      end
   end

`ifdef TLC_PREEMPT_EN
   initial begin
      bus.pre_req = 1'b0;
      bus.pre_idx = '0;
   end
`endif

   initial begin
      bus.t = '0;
      // Reset, then idle start-up into green(0).
      repeat (3) step(1'b1, '0);
      repeat (12) step(1'b0, '0);
      // Sole demand held: green must never end.
      repeat (100) step(1'b0, 4'b0001);
      // Gap-out to approach 2 from a one-cycle pulse.
      repeat (3) step(1'b0, '0);
      step(1'b0, 4'b0100);
      repeat (15) step(1'b0, '0);
      // Max-out with approaches 0 and 1 both held.
      repeat (2) step(1'b1, '0);
      repeat (40) step(1'b0, 4'b0011);
      // Reach green(1), then skip with wrap: 3 then 0, never 2.
      repeat (10) step(1'b0, '0);
      step(1'b0, 4'b1001);
      repeat (30) step(1'b0, '0);
      // Reset on the second yellow cycle.
      step(1'b0, 4'b0100);
      for (int i = 0; i < 40; i++) begin
         if (m_phase == PH_YEL && m_age == 2) break;
         step(1'b0, '0);
      end
      step(1'b1, '0);
      repeat (8) step(1'b0, '0);
      // Randomized traffic with occasional resets.
      for (int i = 0; i < 2000; i++) begin
         bit [N-1:0] tv;
         bit         rv;
         tv = N'($urandom & $urandom);
         rv = ($urandom_range(0, 299) == 0);
         step(rv, tv);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
